// File: rtl/vm_pkg.sv
// Shared constants and types for the vending-machine coin front end.
package vm_pkg;

    localparam int unsigned N_COINS = 4;
    localparam int unsigned VAL_W   = 8;

    // Entry i is the value of denomination input i.
    localparam logic [N_COINS-1:0][VAL_W-1:0] COIN_VALUES = {8'd100, 8'd25, 8'd10, 8'd5};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2
    } coin_q_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a pop frees its slot for a same-cycle push.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty_o masks stale entries.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/coin_queue.sv
// Serializes coin pulses from several denomination inputs into a value bus plus
// one-cycle strobe, holding the value for GAP_CYCLES cycles after each strobe.
module coin_queue import vm_pkg::*; #(
    parameter int unsigned N_COINS    = vm_pkg::N_COINS,
    parameter int unsigned VAL_W      = vm_pkg::VAL_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic [N_COINS-1:0][VAL_W-1:0] COIN_VALUES = vm_pkg::COIN_VALUES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_COINS-1:0] coin_i,
    input  logic               en_i,
    input  logic               ovf_clr_i,
    output logic [VAL_W-1:0]   a_o,
    output logic               c_o,
    output logic               busy_o,
    output logic               overflow_o
);

    localparam int unsigned IDX_W  = (N_COINS > 1) ? $clog2(N_COINS) : 1;
    localparam int unsigned HOLD_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    coin_q_state_e      state_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [VAL_W-1:0]   a_q;
    logic [N_COINS-1:0] pending_q, pending_d;
    logic               ovf_q, ovf_d;

    logic [IDX_W-1:0]   sel_idx;
    logic [N_COINS-1:0] set_c, clr_c, drop_c;
    logic               push_c, pop_c;
    logic [VAL_W-1:0]   fifo_head;
    logic               fifo_full, fifo_empty;

    // Lowest pending denomination wins the FIFO slot.
    always_comb begin
        sel_idx = '0;
        for (int i = N_COINS - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = IDX_W'(i);
        end
    end

    assign pop_c  = (state_q == IDLE) & ~fifo_empty;
    assign push_c = (|pending_q) & (~fifo_full | pop_c);
    assign set_c  = coin_i & {N_COINS{en_i}};
    assign clr_c  = push_c ? (N_COINS'(1) << sel_idx) : '0;
    assign drop_c = set_c & pending_q & ~clr_c;

    // A new pulse on a slot being drained this cycle refills it without a drop.
    always_comb begin
        pending_d = (pending_q & ~clr_c) | set_c;
        ovf_d     = ovf_q;
        if (|drop_c)        ovf_d = 1'b1;
        else if (ovf_clr_i) ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (VAL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_c),
        .data_i  (COIN_VALUES[sel_idx]),
        .pop_i   (pop_c),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Output sequencer: IDLE loads a_q on pop, EMIT strobes, HOLD keeps a_q stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            a_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_c) begin
                        a_q     <= fifo_head;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    state_q    <= HOLD;
                    hold_cnt_q <= HOLD_W'(GAP_CYCLES - 1);
                end
                HOLD: begin
                    if (hold_cnt_q == '0) state_q    <= IDLE;
                    else                  hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_o        = a_q;
    assign c_o        = (state_q == EMIT);
    assign overflow_o = ovf_q;
    assign busy_o     = (|pending_q) | ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_coin_queue.sv
// Self-checking bench for coin_queue: directed vectors, scenario sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_coin_queue;

    localparam int GAP   = 2;
    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] coin_i = 4'b0;
    logic       en_i = 1'b0;
    logic       ovf_clr_i = 1'b0;
    logic [7:0] a_o;
    logic       c_o, busy_o, overflow_o;

    coin_queue #(
        .N_COINS    (4),
        .VAL_W      (8),
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .coin_i     (coin_i),
        .en_i       (en_i),
        .ovf_clr_i  (ovf_clr_i),
        .a_o        (a_o),
        .c_o        (c_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending bits, a value queue, and a countdown of busy output cycles.
    int       vals [4] = '{5, 10, 25, 100};
    bit [3:0] m_pend;
    int       m_q[$];
    int       m_rem;
    int       m_a;
    bit       m_ovf;

    task automatic model_step(input logic [3:0] coin, input logic en, input logic clr, input logic rst);
        bit       pop, can, drop, s, cl;
        bit [3:0] newp;
        int       k;
        if (rst) begin
            m_pend = '0; m_q.delete(); m_rem = 0; m_a = 0; m_ovf = 0;
            return;
        end
        pop = (m_rem == 0) && (m_q.size() > 0);
        k = -1;
        for (int i = 0; i < 4; i++) if (m_pend[i] && k < 0) k = i;
        can  = (k >= 0) && ((m_q.size() < DEPTH) || pop);
        drop = 0;
        for (int i = 0; i < 4; i++) begin
            s  = coin[i] & en;
            cl = can && (k == i);
            if (s && m_pend[i] && !cl) drop = 1;
            newp[i] = (m_pend[i] && !cl) || s;
        end
        if (m_rem > 0) m_rem--;
        else if (pop) begin
            m_a   = m_q.pop_front();
            m_rem = GAP + 1;
        end
        if (can) m_q.push_back(vals[k]);
        if (drop)     m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_pend = newp;
    endtask

    // Per-scenario observation log, indexed by cycles since the scenario began.
    int cyc_n = 0;
    int t0    = 0;
    int st_t[$];
    int st_a[$];
    bit bz[0:255];

    task automatic begin_seq();
        t0 = cyc_n;
        st_t.delete();
        st_a.delete();
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge.
    task automatic cyc(input logic [3:0] coin, input logic en, input logic clr, input logic rst);
        int rel;
        coin_i = coin; en_i = en; ovf_clr_i = clr; rst_i = rst;
        @(posedge clk_i);
        model_step(coin, en, clr, rst);
        @(negedge clk_i);
        cyc_n++;
        rel = cyc_n - t0;
        if (c_o) begin
            st_t.push_back(rel);
            st_a.push_back(int'(a_o));
        end
        if (rel < 256) bz[rel] = busy_o;
        chk("model_c",    int'(c_o),        int'(m_rem == GAP + 1));
        chk("model_a",    int'(a_o),        m_a);
        chk("model_busy", int'(busy_o),     int'((m_pend != 0) || (m_q.size() > 0) || (m_rem > 0)));
        chk("model_ovf",  int'(overflow_o), int'(m_ovf));
    endtask

    typedef struct {
        logic [3:0] coin;
        logic       exp_c;
        logic [7:0] exp_a;
        logic       exp_busy;
    } vec_t;

    vec_t tv [7];

    initial begin
        // Single coin (denomination 2) from an idle, empty queue.
        tv[0] = '{4'b0100, 1'b0, 8'd0,  1'b1};
        tv[1] = '{4'b0000, 1'b0, 8'd0,  1'b1};
        tv[2] = '{4'b0000, 1'b1, 8'd25, 1'b1};
        tv[3] = '{4'b0000, 1'b0, 8'd25, 1'b1};
        tv[4] = '{4'b0000, 1'b0, 8'd25, 1'b1};
        tv[5] = '{4'b0000, 1'b0, 8'd25, 1'b0};
        tv[6] = '{4'b0000, 1'b0, 8'd25, 1'b0};

        @(negedge clk_i);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        cyc(4'b1111, 1'b1, 1'b0, 1'b1);
        chk("reset_a",    int'(a_o), 0);
        chk("reset_c",    int'(c_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_ovf",  int'(overflow_o), 0);

        begin_seq();
        for (int i = 0; i < 7; i++) begin
            cyc(tv[i].coin, 1'b1, 1'b0, 1'b0);
            chk($sformatf("vec%0d_c", i),    int'(c_o),    int'(tv[i].exp_c));
            chk($sformatf("vec%0d_a", i),    int'(a_o),    int'(tv[i].exp_a));
            chk($sformatf("vec%0d_busy", i), int'(busy_o), int'(tv[i].exp_busy));
        end

        // Simultaneous coins drain lowest denomination first, 4 cycles apart.
        begin_seq();
        cyc(4'b1011, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("simul_count", st_t.size(), 3);
        if (st_t.size() == 3) begin
            chk("simul_t0", st_t[0], 3);
            chk("simul_t1", st_t[1], 7);
            chk("simul_t2", st_t[2], 11);
            chk("simul_a0", st_a[0], 5);
            chk("simul_a1", st_a[1], 10);
            chk("simul_a2", st_a[2], 100);
        end
        chk("simul_busy_last_hold", int'(bz[13]), 1);
        chk("simul_busy_fall",      int'(bz[14]), 0);
        chk("simul_ovf",            int'(overflow_o), 0);

        // Repeated pulses on one input eventually find its slot occupied.
        begin_seq();
        for (int i = 0; i < 10; i++) cyc(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("ovf_set", int'(overflow_o), 1);
        cyc(4'b0000, 1'b1, 1'b1, 1'b0);
        chk("ovf_clr", int'(overflow_o), 0);
        for (int i = 0; i < 40; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("ovf_all_5", st_a.size() > 0 ? st_a[0] : -1, 5);
        chk("ovf_drain_busy", int'(busy_o), 0);

        // Disabled inputs are ignored; an already-captured coin still emits.
        begin_seq();
        for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b0, 1'b0, 1'b0);
        chk("en_busy", int'(busy_o), 0);
        chk("en_ovf",  int'(overflow_o), 0);
        cyc(4'b0010, 1'b1, 1'b0, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("en_count", st_t.size(), 1);
        chk("en_a", st_a.size() > 0 ? st_a[0] : -1, 10);

        // Reset in the middle of draining three queued coins.
        begin_seq();
        cyc(4'b0111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        chk("rst_a",    int'(a_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        for (int i = 0; i < 12; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("rst_strobes", st_t.size(), 1);
        chk("rst_a_after", int'(a_o), 0);

        // Back-to-back coins fill the FIFO while the output is busy; nothing is lost.
        begin_seq();
        cyc(4'b0001, 1'b1, 1'b0, 1'b0);
        cyc(4'b0010, 1'b1, 1'b0, 1'b0);
        cyc(4'b0100, 1'b1, 1'b0, 1'b0);
        cyc(4'b1000, 1'b1, 1'b0, 1'b0);
        cyc(4'b0001, 1'b1, 1'b0, 1'b0);
        cyc(4'b0010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("full_count", st_a.size(), 6);
        if (st_a.size() == 6) begin
            chk("full_a0", st_a[0], 5);
            chk("full_a1", st_a[1], 10);
            chk("full_a2", st_a[2], 25);
            chk("full_a3", st_a[3], 100);
            chk("full_a4", st_a[4], 5);
            chk("full_a5", st_a[5], 10);
        end
        chk("full_ovf", int'(overflow_o), 0);

        // Randomized traffic against the model.
        begin_seq();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rc;
            logic       re, rclr, rr;
            rc   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            re   = ($urandom_range(0, 9) != 0);
            rclr = ($urandom_range(0, 15) == 0);
            rr   = ($urandom_range(0, 299) == 0);
            cyc(rc, re, rclr, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
